// File: rtl/multi_timer_pkg.sv
// Shared types and limits for the multi-channel down-counter timer.
package multi_timer_pkg;
  typedef enum logic {IDLE, RUN} timer_state_t;
  typedef enum logic {MODE_PERIODIC = 1'b0, MODE_ONESHOT = 1'b1} timer_mode_t;
  localparam int MAX_CH = 16;
endpackage

// File: rtl/timer_channel.sv
// One timer channel: IDLE/RUN FSM, WIDTH-bit down-counter and terminal-count pulse.
module timer_channel
  import multi_timer_pkg::*;
#(
  parameter int WIDTH = 28
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sync_clr,
  input  logic             ena_eff,
  input  logic             start,
  input  logic             stop,
  input  logic             mode,
  input  logic [WIDTH-1:0] reload,
  output logic             tc,
  output logic             running,
  output logic [WIDTH-1:0] count
);

  timer_state_t     state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             at_zero;

  assign at_zero = (count_q == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  // tc looks at the pre-edge state, so it still fires when a start lands on a terminal count.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    tc      = 1'b0;
    if (state_q == RUN && ena_eff && at_zero) tc = 1'b1;
    if (sync_clr) begin
      state_d = IDLE;
      count_d = '0;
    end else if (stop) begin
      state_d = IDLE;
    end else if (start) begin
      state_d = RUN;
      count_d = reload;
    end else if (state_q == RUN && ena_eff) begin
      if (!at_zero) begin
        count_d = count_q - 1'b1;
      end else begin
        count_d = reload;
        if (timer_mode_t'(mode) == MODE_ONESHOT) state_d = IDLE;
      end
    end
  end

  assign running = (state_q == RUN);
  assign count   = count_q;

endmodule

// File: rtl/multi_timer.sv
// NUM_CH independent down-counter timers sharing one count-enable strobe.
// Define MULTI_TIMER_PRESCALE_EN to divide the enable strobe by PRESCALE before it reaches the channels.
module multi_timer
  import multi_timer_pkg::*;
#(
  parameter int NUM_CH   = 4,
  parameter int WIDTH    = 28,
  parameter int PRESCALE = 50
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    sync_clr,
  input  logic                    ena,
  input  logic [NUM_CH-1:0]       ch_start,
  input  logic [NUM_CH-1:0]       ch_stop,
  input  logic [NUM_CH-1:0]       ch_mode,
  input  logic [NUM_CH*WIDTH-1:0] reload,
  output logic [NUM_CH-1:0]       tc,
  output logic [NUM_CH-1:0]       running,
  output logic [NUM_CH*WIDTH-1:0] count
);

  if (NUM_CH < 1 || NUM_CH > MAX_CH || PRESCALE < 1) begin : g_param_check
    $error("multi_timer: NUM_CH or PRESCALE out of range");
  end

  logic ena_eff;

`ifdef MULTI_TIMER_PRESCALE_EN
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  logic [PW-1:0] pre_q;

  // Starts at zero so the first ena strobe after reset or clear is already effective.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q <= '0;
    end else if (sync_clr) begin
      pre_q <= '0;
    end else if (ena) begin
      pre_q <= (pre_q == '0) ? PW'(PRESCALE - 1) : pre_q - 1'b1;
    end
  end

  assign ena_eff = ena && (pre_q == '0);
`else
  assign ena_eff = ena;
`endif

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    timer_channel #(
      .WIDTH(WIDTH)
    ) u_ch (
      .clk     (clk),
      .rst_n   (rst_n),
      .sync_clr(sync_clr),
      .ena_eff (ena_eff),
      .start   (ch_start[i]),
      .stop    (ch_stop[i]),
      .mode    (ch_mode[i]),
      .reload  (reload[i*WIDTH +: WIDTH]),
      .tc      (tc[i]),
      .running (running[i]),
      .count   (count[i*WIDTH +: WIDTH])
    );
  end

endmodule

// File: tb/tb_multi_timer.sv
// Self-checking bench for multi_timer: vector table, scoreboard queue and tc interval checks.
`timescale 1ns/1ps
module tb_multi_timer;
  localparam int NCH   = 4;
  localparam int WIDTH = 8;
  localparam int W     = 4 + 2 + WIDTH;

  logic                   clk;
  logic                   rst_n;
  logic                   sync_clr;
  logic                   ena;
  logic [NCH-1:0]         ch_start;
  logic [NCH-1:0]         ch_stop;
  logic [NCH-1:0]         ch_mode;
  logic [NCH*WIDTH-1:0]   reload;
  logic [NCH-1:0]         tc;
  logic [NCH-1:0]         running;
  logic [NCH*WIDTH-1:0]   count;

  multi_timer #(
    .NUM_CH  (NCH),
    .WIDTH   (WIDTH),
    .PRESCALE(4)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .sync_clr(sync_clr),
    .ena     (ena),
    .ch_start(ch_start),
    .ch_stop (ch_stop),
    .ch_mode (ch_mode),
    .reload  (reload),
    .tc      (tc),
    .running (running),
    .count   (count)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int           n_checks = 0;
  int           n_fail   = 0;
  string        cur_name = "init";

  function automatic void push(input int ch, input bit e_tc, input bit e_run, input int e_cnt);
    exp_q.push_back({4'(ch), e_tc, e_run, WIDTH'(e_cnt)});
  endfunction

  task automatic drain();
    logic [W-1:0]       e;
    logic [WIDTH+1:0]   act;
    int                 ch;
    while (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      ch  = int'(e[W-1 -: 4]);
      act = {tc[ch], running[ch], count[ch*WIDTH +: WIDTH]};
      n_checks++;
      if (act !== e[WIDTH+1:0]) begin
        n_fail++;
        $display("FAIL %s ch%0d: got tc=%0b run=%0b cnt=%0d, expected tc=%0b run=%0b cnt=%0d",
                 cur_name, ch, act[WIDTH+1], act[WIDTH], act[WIDTH-1:0],
                 e[WIDTH+1], e[WIDTH], e[WIDTH-1:0]);
      end
    end
  endtask

  task automatic check_val(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Inputs change at posedge+1; outputs are compared at the following negedge.
  task automatic step();
    @(negedge clk);
    drain();
    @(posedge clk);
    #1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int ch;
    bit st, sp, md, cl, en;
    int rl;
    bit e_tc, e_run;
    int e_cnt;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input int ch, input bit st, input bit sp, input bit md, input bit cl,
                              input bit en, input int rl, input bit e_tc, input bit e_run,
                              input int e_cnt);
    vec_t v;
    v.ch = ch; v.st = st; v.sp = sp; v.md = md; v.cl = cl; v.en = en; v.rl = rl;
    v.e_tc = e_tc; v.e_run = e_run; v.e_cnt = e_cnt;
    tbl.push_back(v);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic apply(input vec_t v, input int k);
    ch_start = '0;
    ch_stop  = '0;
    sync_clr = v.cl;
    ena      = v.en;
    ch_start[v.ch] = v.st;
    ch_stop[v.ch]  = v.sp;
    ch_mode[v.ch]  = v.md;
    reload[v.ch*WIDTH +: WIDTH] = WIDTH'(v.rl);
    push(v.ch, v.e_tc, v.e_run, v.e_cnt);
    cur_name = $sformatf("vec%0d", k);
    step();
  endtask

  task automatic wait_tc(input int ch, input int limit, output int n);
    n = 0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      n++;
      if (tc[ch]) begin
        @(posedge clk);
        #1;
        return;
      end
      @(posedge clk);
      #1;
    end
    n = limit + 1;
  endtask

  // ---------------- test ----------------
  int exp_period;
  int n;

  initial begin
    rst_n    = 1'b0;
    sync_clr = 1'b0;
    ena      = 1'b0;
    ch_start = '0;
    ch_stop  = '0;
    ch_mode  = '0;
    reload   = '0;
    repeat (2) @(posedge clk);
    #1;
    for (int c = 0; c < NCH; c++) push(c, 0, 0, 0);
    cur_name = "reset_asserted";
    step();
    rst_n = 1'b1;
    for (int c = 0; c < NCH; c++) push(c, 0, 0, 0);
    cur_name = "after_reset";
    step();

`ifndef MULTI_TIMER_PRESCALE_EN
    // ch, st, sp, md, cl, en, rl, e_tc, e_run, e_cnt
    // periodic ch0, reload 3: period 4, then stop holds the count
    add(0, 1, 0, 0, 0, 1, 3, 0, 0, 0);
    add(0, 0, 0, 0, 0, 1, 3, 0, 1, 3);
    add(0, 0, 0, 0, 0, 1, 3, 0, 1, 2);
    add(0, 0, 0, 0, 0, 1, 3, 0, 1, 1);
    add(0, 0, 0, 0, 0, 1, 3, 1, 1, 0);
    add(0, 0, 0, 0, 0, 1, 3, 0, 1, 3);
    add(0, 0, 0, 0, 0, 1, 3, 0, 1, 2);
    add(0, 0, 0, 0, 0, 1, 3, 0, 1, 1);
    add(0, 0, 0, 0, 0, 1, 3, 1, 1, 0);
    add(0, 0, 0, 0, 0, 1, 3, 0, 1, 3);
    add(0, 0, 1, 0, 0, 1, 3, 0, 1, 2);
    add(0, 0, 0, 0, 0, 1, 3, 0, 0, 2);
    add(0, 0, 0, 0, 0, 1, 3, 0, 0, 2);
    // one-shot ch1, reload 2, gated enable
    add(1, 1, 0, 1, 0, 1, 2, 0, 0, 0);
    add(1, 0, 0, 1, 0, 1, 2, 0, 1, 2);
    add(1, 0, 0, 1, 0, 0, 2, 0, 1, 1);
    add(1, 0, 0, 1, 0, 1, 2, 0, 1, 1);
    add(1, 0, 0, 1, 0, 0, 2, 0, 1, 0);
    add(1, 0, 0, 1, 0, 1, 2, 1, 1, 0);
    add(1, 0, 0, 1, 0, 0, 2, 0, 0, 2);
    add(1, 0, 0, 1, 0, 1, 2, 0, 0, 2);
    // priority on ch2: stop beats start, sync_clr beats start
    add(2, 1, 1, 0, 0, 1, 7, 0, 0, 0);
    add(2, 0, 0, 0, 0, 1, 7, 0, 0, 0);
    add(2, 1, 0, 0, 0, 1, 7, 0, 0, 0);
    add(2, 1, 0, 0, 1, 1, 7, 0, 1, 7);
    add(2, 0, 0, 0, 0, 1, 7, 0, 0, 0);
    add(0, 0, 0, 0, 0, 1, 3, 0, 0, 0);
    // ch3: reload change mid-run, start on terminal count, switch to one-shot
    add(3, 1, 0, 0, 0, 1, 5, 0, 0, 0);
    add(3, 0, 0, 0, 0, 1, 5, 0, 1, 5);
    add(3, 0, 0, 0, 0, 1, 5, 0, 1, 4);
    add(3, 0, 0, 0, 0, 1, 1, 0, 1, 3);
    add(3, 0, 0, 0, 0, 1, 1, 0, 1, 2);
    add(3, 0, 0, 0, 0, 1, 1, 0, 1, 1);
    add(3, 0, 0, 0, 0, 1, 1, 1, 1, 0);
    add(3, 0, 0, 0, 0, 1, 1, 0, 1, 1);
    add(3, 0, 0, 0, 0, 1, 1, 1, 1, 0);
    add(3, 0, 0, 0, 0, 1, 1, 0, 1, 1);
    add(3, 1, 0, 0, 0, 1, 4, 1, 1, 0);
    add(3, 0, 0, 0, 0, 1, 4, 0, 1, 4);
    add(3, 0, 0, 0, 0, 1, 4, 0, 1, 3);
    add(3, 0, 0, 1, 0, 1, 4, 0, 1, 2);
    add(3, 0, 0, 1, 0, 1, 4, 0, 1, 1);
    add(3, 0, 0, 1, 0, 1, 4, 1, 1, 0);
    add(3, 0, 0, 1, 0, 1, 4, 0, 0, 4);
    for (int k = 0; k < tbl.size(); k++) apply(tbl[k], k);
    exp_period = 2;
`else
    exp_period = 8;
`endif

    // tc spacing on ch0 with reload 1 and ena held high
    ch_start = '0;
    ch_stop  = '0;
    ch_mode  = '0;
    sync_clr = 1'b0;
    ena      = 1'b1;
    reload[0 +: WIDTH] = WIDTH'(1);
    ch_start[0] = 1'b1;
    step();
    ch_start[0] = 1'b0;
    wait_tc(0, 40, n);
    check_val("first_tc_seen", int'(n <= 40), 1);
    for (int p = 0; p < 3; p++) begin
      wait_tc(0, 40, n);
      check_val($sformatf("tc_interval%0d", p), n, exp_period);
    end

    // asynchronous reset in the middle of a run
    ch_stop[0] = 1'b1;
    step();
    ch_stop[0] = 1'b0;
    reload[0 +: WIDTH] = WIDTH'(3);
    ch_start[0] = 1'b1;
    step();
    ch_start[0] = 1'b0;
    repeat (2) step();
    #($urandom_range(1, 3));
    rst_n = 1'b0;
    #1;
    push(0, 0, 0, 0);
    cur_name = "async_reset_midrun";
    drain();
    @(posedge clk);
    #1;
    push(0, 0, 0, 0);
    cur_name = "reset_held";
    step();
    rst_n = 1'b1;
    ena   = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
